sha256_msg_ctrl: RTL
====================

Name: sha256_msg_ctrl

Overview:
- Upstream message front-end for the sha256 compression core.
- Accepts an arbitrary-length byte stream per message and applies SHA-256 padding (0x80, zeros, 64-bit bit-length).
- Slices the stream into 512-bit chunks and drives them into the core with the chained hash, then waits for each core result before issuing the next chunk.
- Presents the final 256-bit digest with a one-cycle valid pulse. One message in flight at a time.

Parameters:
- LEN_W, 32, width of message byte counter; messages of 2^LEN_W bytes or more are unsupported (counter wraps).
- CORE_LAT, 64, upper bound of core in_vld-to-out_vld latency in cycles; sizes the post-reset flush.
- IV, 256'h5be0cd191f83d9ab9b05688c510e527fa54ff53a3c6ef372bb67ae856a09e667, initial hash, packed {h7..h0}, h0 at LSB.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_data  in  8  message byte.
- s_vld  in  1  s_data/s_last/s_empty valid.
- s_last  in  1  final beat of message.
- s_empty  in  1  with s_last: beat carries no byte (zero-length message or empty tail).
- s_rdy  out  1  controller accepts beat this cycle.
- chunk  out  512  block to core; message byte i of block at chunk[8*i+7:8*i].
- in_hash  out  256  chaining hash to core, {h7..h0}.
- in_vld  out  1  one-cycle chunk issue pulse.
- out_hash  in  256  core result.
- out_vld  in  1  core result valid.
- digest  out  256  final hash, {h7..h0}, held until next digest.
- digest_vld  out  1  one-cycle pulse.
- err  out  1  sticky timeout flag (see Optional Feature).

Behaviour:
- Reset: all outputs 0. Buffer, byte index, length counter and H cleared; H=IV. State FLUSH.
- FLUSH: s_rdy=0; out_vld ignored; after CORE_LAT+1 cycles go to FILL. Covers a reset mid-operation with a result still in the core.
- FILL: s_rdy=1. Beat accepted on s_vld&s_rdy.
  - Non-empty byte: written at index idx; idx and the length counter increment.
  - Byte at idx=63 without s_last: go to ISSUE with final=0; next block starts clean.
- s_last accepted: let n = bytes in the current block after this beat (0..64).
  - n<=55: write 0x80 at n, zeros, and the 64-bit big-endian bit length (len*8, zero-extended) at bytes 56..63 (byte 56 = MSB). ISSUE with final=1.
  - 56<=n<=63: write 0x80 at n, zeros after. ISSUE with final=0; then PAD.
  - n=64: ISSUE with final=0; then PAD with 0x80 pending.
- PAD: build an all-zero block, with 0x80 at byte 0 if still pending and the length at bytes 56..63. ISSUE with final=1. Takes one cycle.
- ISSUE: in_vld=1 for exactly one cycle, with chunk=buffer and in_hash=H. Then WAIT. s_rdy=0 from ISSUE through DONE.
- WAIT: on out_vld, H<=out_hash.
  - final=0: clear buffer; go to PAD if padding is pending, else FILL.
  - final=1: go to DONE.
  - out_vld outside WAIT is ignored.
- DONE: digest<=out result, digest_vld=1 for one cycle. H<=IV, length<=0, idx<=0. Go to FILL.
- Zero-length message (s_last&s_empty with len=0): single block 0x80 at byte 0, length 0.
- s_vld low in FILL: no state change, no timeout.
- Rising rst in any state: immediate return to reset values, current message discarded, no digest.
- chunk and in_hash are held stable outside ISSUE (last issued values).

Optional Feature:
- SHA256_WAIT_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT.
  - If out_vld is not seen within CORE_LAT+4 cycles, set err=1 (sticky until rst), discard the message, and go to FLUSH.
  - A late result arriving during FLUSH is ignored.
- Undefined: no counter; WAIT is unbounded; err tied to 0.

Test Plan:
- "abc" (0x61,0x62,0x63, last on 0x63) -> one in_vld pulse; chunk bytes 3=0x80, byte 63=0x18; digest=256'hf20015ad_b410ff61_96177a9c_b00361a3_5dae2223_414140de_8f01cfea_ba7816bf.
- Zero-length (single beat s_last=1,s_empty=1) -> one block, byte0=0x80, rest 0; digest=256'h7852b855_a495991b_649b934c_27ae41e4_996fb924_9afbf4c8_98fc1c14_e3b0c442.
- 55-byte random message -> exactly 1 in_vld; 56-byte -> 2, second block bytes 0..55 zero, byte 63=0xC0; 64-byte -> 2, second block byte0=0x80, bytes 62..63=0x02,0x00. All digests match the model.
- Random s_vld gaps and a 200-byte message -> 4 in_vld pulses, each in_hash equals the previous out_hash; s_rdy=0 throughout WAIT; digest matches the model.
- rst asserted in WAIT of a 3-block message -> all outputs 0 next cycle; s_rdy low for CORE_LAT+1 cycles; stale out_vld produces no digest; the next "abc" yields the correct digest.
- SHA256_WAIT_TIMEOUT_EN, core out_vld forced low -> err=1 exactly CORE_LAT+4 cycles after in_vld; no digest_vld; err stays 1 until rst.

Source files
------------

// File: rtl/sha256_msg_ctrl.sv
// sha256_msg_ctrl: byte-stream front-end for a SHA-256 compression core.
// Pads each message (0x80, zeros, 64-bit big-endian bit length), slices it into
// 512-bit blocks, chains the hash through the core and emits the final digest.
// Optional feature macro: SHA256_WAIT_TIMEOUT_EN (bounded wait for the core,
// sticky err flag on expiry).
// Handshake: a beat transfers on a rising edge where s_vld and s_rdy are both 1;
// in_vld is a one-cycle issue pulse; out_vld is honoured only while waiting
// for the issued block, and ignored everywhere else.
module sha256_msg_ctrl #(
    parameter int           LEN_W    = 32,
    parameter int           CORE_LAT = 64,
    parameter logic [255:0] IV       = 256'h5be0cd191f83d9ab9b05688c510e527fa54ff53a3c6ef372bb67ae856a09e667
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   s_data,
    input  logic         s_vld,
    input  logic         s_last,
    input  logic         s_empty,
    output logic         s_rdy,
    output logic [511:0] chunk,
    output logic [255:0] in_hash,
    output logic         in_vld,
    input  logic [255:0] out_hash,
    input  logic         out_vld,
    output logic [255:0] digest,
    output logic         digest_vld,
    output logic         err
);

    localparam int CNT_W = $clog2(CORE_LAT + 5) + 1;

    typedef enum logic [2:0] {
        ST_FLUSH,
        ST_FILL,
        ST_PAD,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t state, state_d;

    logic [511:0]     buf_q, fill_buf, chunk_q;
    logic [255:0]     h_q, in_hash_q, digest_q;
    logic [5:0]       idx;
    logic [LEN_W-1:0] len, len_inc;
    logic [6:0]       n;
    logic             has_byte, is_final, pad_pend, pad80;
    logic [CNT_W-1:0] cnt;
    logic             cnt_run, timeout;
    logic             digest_vld_q, err_q;

    // Byte 56 of a block carries the most significant byte of the bit length.
    function automatic logic [63:0] bswap64(input logic [63:0] v);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = v[8*(7-i) +: 8];
        return r;
    endfunction

    // An s_last beat flagged empty carries no byte; s_empty alone means nothing.
    assign has_byte = !(s_last && s_empty);
    assign n        = {1'b0, idx} + {6'd0, has_byte};
    assign len_inc  = len + LEN_W'(has_byte);

`ifdef SHA256_WAIT_TIMEOUT_EN
    assign cnt_run = (state == ST_FLUSH) || (state == ST_WAIT);
    assign timeout = (state == ST_WAIT) && !out_vld && (cnt == CNT_W'(CORE_LAT + 2));
`else
    assign cnt_run = (state == ST_FLUSH);
    assign timeout = 1'b0;
`endif

    // Block contents after accepting the current beat, including padding on s_last.
    // Bytes above idx are already zero because the buffer is cleared per block.
    always_comb begin
        fill_buf = buf_q;
        if (has_byte) fill_buf[{idx, 3'b000} +: 8] = s_data;
        if (s_last) begin
            if (!n[6]) fill_buf[{n[5:0], 3'b000} +: 8] = 8'h80;
            if (n <= 7'd55) fill_buf[511:448] = bswap64(64'(len_inc) << 3);
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d = state;
        s_rdy   = 1'b0;
        in_vld  = 1'b0;
        case (state)
            ST_FLUSH: if (cnt == CNT_W'(CORE_LAT)) state_d = ST_FILL;
            ST_FILL: begin
                s_rdy = 1'b1;
                if (s_vld && (s_last || (idx == 6'd63))) state_d = ST_ISSUE;
            end
            ST_PAD:   state_d = ST_ISSUE;
            ST_ISSUE: begin
                in_vld  = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (out_vld) begin
                    if (is_final)      state_d = ST_DONE;
                    else if (pad_pend) state_d = ST_PAD;
                    else               state_d = ST_FILL;
                end else if (timeout) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_DONE:  state_d = ST_FILL;
            default:  state_d = ST_FLUSH;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_FLUSH;
        else     state <= state_d;
    end

    // Shared flush/wait cycle counter, restarted on every state change.
    always_ff @(posedge clk) begin
        if (rst || !cnt_run || (state_d != state)) cnt <= '0;
        else                                       cnt <= cnt + 1'b1;
    end

    // Message buffer, length, chaining hash and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q        <= '0;
            idx          <= '0;
            len          <= '0;
            h_q          <= IV;
            is_final     <= 1'b0;
            pad_pend     <= 1'b0;
            pad80        <= 1'b0;
            chunk_q      <= '0;
            in_hash_q    <= '0;
            digest_q     <= '0;
            digest_vld_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            digest_vld_q <= 1'b0;
            case (state)
                ST_FILL: if (s_vld) begin
                    buf_q <= fill_buf;
                    len   <= len_inc;
                    idx   <= s_last ? 6'd0 : idx + {5'd0, has_byte};
                    if (s_last) begin
                        is_final <= (n <= 7'd55);
                        pad_pend <= (n > 7'd55);
                        pad80    <= n[6];
                    end else begin
                        is_final <= 1'b0;
                        pad_pend <= 1'b0;
                        pad80    <= 1'b0;
                    end
                end
                ST_PAD: begin
                    buf_q[7:0]     <= pad80 ? 8'h80 : 8'h00;
                    buf_q[511:448] <= bswap64(64'(len) << 3);
                    is_final       <= 1'b1;
                    pad_pend       <= 1'b0;
                end
                ST_ISSUE: begin
                    chunk_q   <= buf_q;
                    in_hash_q <= h_q;
                end
                ST_WAIT: begin
                    if (out_vld) begin
                        h_q <= out_hash;
                        if (!is_final) buf_q <= '0;
                    end else if (timeout) begin
                        err_q    <= 1'b1;
                        buf_q    <= '0;
                        idx      <= '0;
                        len      <= '0;
                        h_q      <= IV;
                        is_final <= 1'b0;
                        pad_pend <= 1'b0;
                        pad80    <= 1'b0;
                    end
                end
                ST_DONE: begin
                    digest_q     <= h_q;
                    digest_vld_q <= 1'b1;
                    h_q          <= IV;
                    len          <= '0;
                    idx          <= '0;
                    buf_q        <= '0;
                end
                default: ;
            endcase
        end
    end

    // During ISSUE the live buffer/hash are presented; afterwards the last issued copy.
    assign chunk      = (state == ST_ISSUE) ? buf_q : chunk_q;
    assign in_hash    = (state == ST_ISSUE) ? h_q : in_hash_q;
    assign digest     = digest_q;
    assign digest_vld = digest_vld_q;
    assign err        = err_q;

endmodule
